fir_coeff_sender: RTL and testbench

- Front-end driver for the adaptive-coefficient FIR: owns the FIR's input-side signals x_n, s_axis_fir_tvalid and s_set_coeffs.
- Normally forwards an upstream sample stream to the FIR.
- On request, pauses the stream and serialises a new coefficient set using the FIR load protocol: s_set_coeffs=1, tvalid=0, one coefficient per cycle, then a guard phase before streaming resumes.

---
 rtl/fir_coeff_sender.sv | 214 +++++++++++++++++++++
 tb/tb_fir_coeff_sender.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_sender.sv
// fir_coeff_sender: front-end driver for the adaptive-coefficient FIR.
// Forwards an upstream sample stream to the FIR and, on request, pauses the
// stream to serialise a new coefficient set (s_set_coeffs=1, tvalid=0, one
// coefficient per cycle, index 0 first), followed by a guard phase.
// Optional feature macro: FIR_SENDER_ZERO_FLUSH_EN -- after the guard phase,
// inject FLUSH_LEN zero samples to clear the FIR delay line before streaming.
module fir_coeff_sender #(
  parameter int DATA_W     = 8,
  parameter int NUM_COEFFS = 3,
  parameter int GAP_CYCLES = 2,
  parameter int FLUSH_LEN  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W*NUM_COEFFS-1:0] coef_in,
  input  logic                         load_req,
  output logic                         busy,
  output logic                         load_done,
  output logic [DATA_W-1:0]            x_n,
  output logic                         s_axis_fir_tvalid,
  output logic                         s_set_coeffs
);

  localparam int IDX_W = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COEFFS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
`ifdef FIR_SENDER_ZERO_FLUSH_EN
  localparam int FL_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_LEN - 1);
  localparam logic [FL_W-1:0] FL_ONE  = FL_W'(1);
`endif

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_LOAD   = 2'd1,
`ifdef FIR_SENDER_ZERO_FLUSH_EN
    ST_GAP    = 2'd2,
    ST_FLUSH  = 2'd3
`else
    ST_GAP    = 2'd2
`endif
  } state_t;

  state_t                  state_r, state_nxt;
  logic [IDX_W-1:0]        idx_r, idx_nxt;
  logic [GAP_W-1:0]        gap_cnt_r, gap_cnt_nxt;
`ifdef FIR_SENDER_ZERO_FLUSH_EN
  logic [FL_W-1:0]         flush_cnt_r, flush_cnt_nxt;
`endif
  logic [DATA_W-1:0]       shadow_r [NUM_COEFFS];
  logic [DATA_W-1:0]       shadow_nxt [NUM_COEFFS];
  logic [DATA_W-1:0]       pend_shadow_r [NUM_COEFFS];
  logic [DATA_W-1:0]       pend_shadow_nxt [NUM_COEFFS];
  logic                    pending_r, pending_nxt;
  logic [DATA_W-1:0]       x_n_r, x_n_nxt;
  logic                    tvalid_r, tvalid_nxt;
  logic                    set_coeffs_r, set_coeffs_nxt;
  logic                    busy_r, busy_nxt;
  logic                    load_done_r, load_done_nxt;

  // Upstream handshake: samples are accepted only while streaming.
  assign in_ready          = (state_r == ST_STREAM);
  assign busy              = busy_r;
  assign load_done         = load_done_r;
  assign x_n               = x_n_r;
  assign s_axis_fir_tvalid = tvalid_r;
  assign s_set_coeffs      = set_coeffs_r;

  // Next-state and next-output computation for the sender FSM.
  always_comb begin
    state_nxt      = state_r;
    idx_nxt        = idx_r;
    gap_cnt_nxt    = gap_cnt_r;
`ifdef FIR_SENDER_ZERO_FLUSH_EN
    flush_cnt_nxt  = flush_cnt_r;
`endif
    shadow_nxt      = shadow_r;
    pend_shadow_nxt = pend_shadow_r;
    pending_nxt    = pending_r;
    x_n_nxt        = x_n_r;
    tvalid_nxt     = 1'b0;
    set_coeffs_nxt = 1'b0;
    load_done_nxt  = 1'b0;

    case (state_r)
      ST_STREAM: begin
        // The sample presented this cycle is forwarded even if a load starts.
        if (in_valid) begin
          x_n_nxt = in_data;
        end else begin
          x_n_nxt = x_n_r;
        end
        tvalid_nxt = in_valid;
        if (load_req) begin
          // A fresh request supersedes any older pending set.
          for (int k = 0; k < NUM_COEFFS; k++) begin
            shadow_nxt[k] = coef_in[k*DATA_W +: DATA_W];
          end
          pending_nxt = 1'b0;
          idx_nxt     = '0;
          state_nxt   = ST_LOAD;
        end else if (pending_r) begin
          shadow_nxt  = pend_shadow_r;
          pending_nxt = 1'b0;
          idx_nxt     = '0;
          state_nxt   = ST_LOAD;
        end else begin
          state_nxt = ST_STREAM;
        end
      end
      ST_LOAD: begin
        x_n_nxt        = shadow_r[idx_r];
        set_coeffs_nxt = 1'b1;
        if (idx_r == IDX_LAST) begin
          idx_nxt     = '0;
          gap_cnt_nxt = '0;
          state_nxt   = ST_GAP;
        end else begin
          idx_nxt = idx_r + IDX_ONE;
        end
      end
      ST_GAP: begin
        x_n_nxt = '0;
        if (gap_cnt_r == GAP_LAST) begin
          gap_cnt_nxt = '0;
`ifdef FIR_SENDER_ZERO_FLUSH_EN
          flush_cnt_nxt = '0;
          state_nxt     = ST_FLUSH;
`else
          load_done_nxt = 1'b1;
          state_nxt     = ST_STREAM;
`endif
        end else begin
          gap_cnt_nxt = gap_cnt_r + GAP_ONE;
        end
      end
`ifdef FIR_SENDER_ZERO_FLUSH_EN
      ST_FLUSH: begin
        x_n_nxt    = '0;
        tvalid_nxt = 1'b1;
        if (flush_cnt_r == FL_LAST) begin
          flush_cnt_nxt = '0;
          load_done_nxt = 1'b1;
          state_nxt     = ST_STREAM;
        end else begin
          flush_cnt_nxt = flush_cnt_r + FL_ONE;
        end
      end
`endif
      default: begin
        x_n_nxt   = '0;
        state_nxt = ST_STREAM;
      end
    endcase

    // Requests arriving mid-load are parked; the latest one wins.
    if (load_req && (state_r != ST_STREAM)) begin
      pending_nxt = 1'b1;
      for (int k = 0; k < NUM_COEFFS; k++) begin
        pend_shadow_nxt[k] = coef_in[k*DATA_W +: DATA_W];
      end
    end else begin
      pending_nxt = pending_nxt;
    end

    busy_nxt = (state_nxt != ST_STREAM) | pending_nxt;
  end

  // State, counters, shadow registers and registered FIR-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_STREAM;
      idx_r        <= '0;
      gap_cnt_r    <= '0;
`ifdef FIR_SENDER_ZERO_FLUSH_EN
      flush_cnt_r  <= '0;
`endif
      for (int k = 0; k < NUM_COEFFS; k++) begin
        shadow_r[k]      <= '0;
        pend_shadow_r[k] <= '0;
      end
      pending_r    <= 1'b0;
      x_n_r        <= '0;
      tvalid_r     <= 1'b0;
      set_coeffs_r <= 1'b0;
      busy_r       <= 1'b0;
      load_done_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      idx_r        <= idx_nxt;
      gap_cnt_r    <= gap_cnt_nxt;
`ifdef FIR_SENDER_ZERO_FLUSH_EN
      flush_cnt_r  <= flush_cnt_nxt;
`endif
      for (int k = 0; k < NUM_COEFFS; k++) begin
        shadow_r[k]      <= shadow_nxt[k];
        pend_shadow_r[k] <= pend_shadow_nxt[k];
      end
      pending_r    <= pending_nxt;
      x_n_r        <= x_n_nxt;
      tvalid_r     <= tvalid_nxt;
      set_coeffs_r <= set_coeffs_nxt;
      busy_r       <= busy_nxt;
      load_done_r  <= load_done_nxt;
    end
  end

endmodule

// File: tb/tb_fir_coeff_sender.sv
// Self-checking bench for fir_coeff_sender (default build, no zero flush).
// A scoreboard queue holds expected FIR-side transfers {set_coeffs, x_n};
// a monitor pops one whenever tvalid or set_coeffs is seen high.
module tb_fir_coeff_sender;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] coef_in;
  logic        load_req;
  logic        busy;
  logic        load_done;
  logic [7:0]  x_n;
  logic        s_axis_fir_tvalid;
  logic        s_set_coeffs;

  int tests_run;
  int fails;
  logic [8:0] exp_q[$];

  fir_coeff_sender dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .coef_in           (coef_in),
    .load_req          (load_req),
    .busy              (busy),
    .load_done         (load_done),
    .x_n               (x_n),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .s_set_coeffs      (s_set_coeffs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] v(logic ir, logic ld, logic sc, logic tv, logic bz, logic [7:0] x);
    return {ir, ld, sc, tv, bz, x};
  endfunction

  // Directed per-cycle check of {in_ready, load_done, set_coeffs, tvalid, busy, x_n}.
  task automatic chk_cyc(string tag, int k, logic [12:0] exp);
    logic [12:0] act;
    act = {in_ready, load_done, s_set_coeffs, s_axis_fir_tvalid, busy, x_n};
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s k=%0d got ir/ld/sc/tv/bz/x=%b/%b/%b/%b/%b/%h want %b/%b/%b/%b/%b/%h",
               tag, k, act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic monitor_loop();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset && (s_axis_fir_tvalid || s_set_coeffs)) begin
        tests_run++;
        if (s_axis_fir_tvalid && s_set_coeffs) begin
          fails++;
          $display("FAIL invariant tvalid and set_coeffs both high, x_n=%h", x_n);
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_xfer got set=%b x_n=%h want nothing", s_set_coeffs, x_n);
        end else begin
          e = exp_q.pop_front();
          if ({s_set_coeffs, x_n} !== e) begin
            fails++;
            $display("FAIL xfer got set=%b x_n=%h want set=%b x_n=%h", s_set_coeffs, x_n, e[8], e[7:0]);
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    logic [7:0] d [4];
    d[0] = 8'd0; d[1] = 8'd1; d[2] = 8'd0; d[3] = 8'd0;

    // Reset
    reset = 1'b0; in_data = 8'd0; in_valid = 1'b0; coef_in = 24'd0; load_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_cyc("reset_state", 0, v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

    // Test 1: stream 0,1,0,0
    for (int i = 0; i < 4; i++) begin
      in_data = d[i]; in_valid = 1'b1;
      exp_q.push_back({1'b0, d[i]});
      step();
    end
    in_valid = 1'b0;
    step();
    chk_cyc("stream_idle", 0, v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

    // Test 2: load {3,2,1}
    in_data = 8'h04; in_valid = 1'b1; coef_in = {8'd3, 8'd2, 8'd1}; load_req = 1'b1;
    exp_q.push_back({1'b0, 8'h04});
    exp_q.push_back({1'b1, 8'h01});
    exp_q.push_back({1'b1, 8'h02});
    exp_q.push_back({1'b1, 8'h03});
    step();
    load_req = 1'b0; in_valid = 1'b0;
    chk_cyc("load", 1, v(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04));
    step(); chk_cyc("load", 2, v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01));
    step(); chk_cyc("load", 3, v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02));
    step(); chk_cyc("load", 4, v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03));
    step(); chk_cyc("load", 5, v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    step(); chk_cyc("load", 6, v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    step(); chk_cyc("load", 7, v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

    // Test 3: second request during LOAD becomes pending
    in_data = 8'h11; in_valid = 1'b1; coef_in = {8'd6, 8'd5, 8'd4}; load_req = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h04});
    exp_q.push_back({1'b1, 8'h05});
    exp_q.push_back({1'b1, 8'h06});
    step();
    chk_cyc("pend", 1, v(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11));
    in_valid = 1'b0; coef_in = {8'd9, 8'd8, 8'd7}; load_req = 1'b1;
    exp_q.push_back({1'b1, 8'h07});
    exp_q.push_back({1'b1, 8'h08});
    exp_q.push_back({1'b1, 8'h09});
    step(); load_req = 1'b0; coef_in = 24'd0;
    chk_cyc("pend", 2,  v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04));
    step(); chk_cyc("pend", 3,  v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05));
    step(); chk_cyc("pend", 4,  v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h06));
    step(); chk_cyc("pend", 5,  v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    step(); chk_cyc("pend", 6,  v(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00));
    step(); chk_cyc("pend", 7,  v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    step(); chk_cyc("pend", 8,  v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07));
    step(); chk_cyc("pend", 9,  v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08));
    step(); chk_cyc("pend", 10, v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h09));
    step(); chk_cyc("pend", 11, v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    step(); chk_cyc("pend", 12, v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    for (int k = 13; k < 17; k++) begin
      step(); chk_cyc("no_third_load", k, v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    end

    // Test 5: bubbles 5,6,7 with valid 1,0,1
    in_data = 8'd5; in_valid = 1'b1; exp_q.push_back({1'b0, 8'd5});
    step(); chk_cyc("bubble", 1, v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5));
    in_data = 8'd6; in_valid = 1'b0;
    step(); chk_cyc("bubble", 2, v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5));
    in_data = 8'd7; in_valid = 1'b1; exp_q.push_back({1'b0, 8'd7});
    step(); chk_cyc("bubble", 3, v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd7));
    in_valid = 1'b0;
    step();

    // Test 4: asynchronous reset on the 2nd LOAD cycle, with a request pending
    in_data = 8'h22; in_valid = 1'b1; coef_in = {8'd3, 8'd2, 8'd1}; load_req = 1'b1;
    exp_q.push_back({1'b0, 8'h22});
    step();
    chk_cyc("rst_mid", 1, v(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22));
    in_valid = 1'b0; coef_in = {8'd9, 8'd8, 8'd7}; load_req = 1'b1;
    step(); load_req = 1'b0;
    chk_cyc("rst_mid", 2, v(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01));
    #1 reset = 1'b0;
    #1 chk_cyc("rst_async", 0, v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(); chk_cyc("rst_after", k, v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    end

    // Stream still works after reset
    in_data = 8'h5a; in_valid = 1'b1; exp_q.push_back({1'b0, 8'h5a});
    step(); in_valid = 1'b0;
    chk_cyc("post_rst_stream", 0, v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5a));
    step(); step();

    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    fork
      monitor_loop();
      stimulus();
    join_any
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
